// File: rtl/ls_pkg.sv
// Shared types and helpers for the latch/shift error-counter window sequencer.
package ls_pkg;
  localparam int CNT_W = 32;
  localparam int TOT_W = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_COUNT,
    ST_HOLD
  } state_t;

  // Unsigned add clamped to lim; the extra sum bit catches carry-out.
  function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                               input logic [TOT_W-1:0] b,
                                               input logic [TOT_W-1:0] lim);
    logic [TOT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) return lim;
    return sum[TOT_W-1:0];
  endfunction
endpackage

// File: rtl/ls_cnt_seq_if.sv
// Host/counter-side signal bundle of the window sequencer.
interface ls_cnt_seq_if #(parameter int WIN_W = 32) ();
  import ls_pkg::*;

  logic             START;
  logic             STOP;
  logic [WIN_W-1:0] WIN_LEN;
  logic [15:0]      NUM_WIN;
  logic [1:0]       DLY_SEL;
  logic [CNT_W-1:0] ERR_CNT;
  logic             COMP_OUT;
  logic             RST_PER;
  logic [1:0]       CLK_CTRL;
  logic [CNT_W-1:0] RESULT;
  logic             RESULT_VALID;
  logic             RESULT_ACK;
  logic [TOT_W-1:0] TOT_ERR;
  logic [15:0]      WIN_DONE;
  logic             BUSY;
  logic             ABORTED;

  modport master (
    output START, STOP, WIN_LEN, NUM_WIN, DLY_SEL, ERR_CNT, COMP_OUT, RESULT_ACK,
    input  RST_PER, CLK_CTRL, RESULT, RESULT_VALID, TOT_ERR, WIN_DONE, BUSY, ABORTED
  );

  modport slave (
    input  START, STOP, WIN_LEN, NUM_WIN, DLY_SEL, ERR_CNT, COMP_OUT, RESULT_ACK,
    output RST_PER, CLK_CTRL, RESULT, RESULT_VALID, TOT_ERR, WIN_DONE, BUSY, ABORTED
  );
endinterface

// File: rtl/ls_cyc_timer.sv
// Loadable down-counter; zero is high once the loaded count has run out.
module ls_cyc_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/ls_cnt_seq.sv
// Measurement-window sequencer: runs CLEAR/SETTLE/COUNT windows on the error
// counter and hands each exact window count to the host over valid/ack.
module ls_cnt_seq
  import ls_pkg::*;
#(
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 4,
  parameter int WIN_W      = 32
) (
  input  logic CLK,
  input  logic RST,
  ls_cnt_seq_if.slave bus
);
  localparam logic [TOT_W-1:0] LIM32 = {{(TOT_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [TOT_W-1:0] LIM40 = {TOT_W{1'b1}};

  state_t           state, state_nx;
  logic [WIN_W-1:0] win_len_q;
  logic [15:0]      num_win_q;
  logic             tmr_load, tmr_zero;
  logic [WIN_W-1:0] tmr_val;
  logic             start_ok, capture, ack_ok, abort;
  logic [TOT_W-1:0] win_sum;
  logic [CNT_W-1:0] win_err;

  ls_cyc_timer #(.W(WIN_W)) u_tmr (
    .clk  (CLK),
    .rst  (RST),
    .load (tmr_load),
    .val  (tmr_val),
    .zero (tmr_zero)
  );

  // COMP_OUT of the final COUNT cycle is not yet folded into ERR_CNT.
  assign win_sum = sat_add({{(TOT_W-CNT_W){1'b0}}, bus.ERR_CNT},
                           {{(TOT_W-1){1'b0}}, bus.COMP_OUT}, LIM32);
  assign win_err = win_sum[CNT_W-1:0];
  assign bus.BUSY = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    start_ok = 1'b0;
    capture  = 1'b0;
    ack_ok   = 1'b0;
    abort    = 1'b0;
    if (state != ST_IDLE && bus.STOP) begin
      state_nx = ST_IDLE;
      abort    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (bus.START && !bus.STOP) begin
          start_ok = 1'b1;
          state_nx = ST_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = WIN_W'(CLR_CYC - 1);
        end
        ST_CLEAR: if (tmr_zero) begin
          state_nx = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = WIN_W'(SETTLE_CYC - 1);
        end
        ST_SETTLE: if (tmr_zero) begin
          state_nx = ST_COUNT;
          tmr_load = 1'b1;
          tmr_val  = (win_len_q == '0) ? '0 : win_len_q - 1'b1;
        end
        ST_COUNT: if (tmr_zero) begin
          state_nx = ST_HOLD;
          capture  = 1'b1;
        end
        ST_HOLD: if (bus.RESULT_ACK) begin
          ack_ok = 1'b1;
          if (num_win_q != '0 && bus.WIN_DONE == num_win_q) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_CLEAR;
            tmr_load = 1'b1;
            tmr_val  = WIN_W'(CLR_CYC - 1);
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= ST_IDLE;
      win_len_q        <= '0;
      num_win_q        <= '0;
      bus.RST_PER      <= 1'b1;
      bus.CLK_CTRL     <= '0;
      bus.RESULT       <= '0;
      bus.RESULT_VALID <= 1'b0;
      bus.TOT_ERR      <= '0;
      bus.WIN_DONE     <= '0;
      bus.ABORTED      <= 1'b0;
    end else begin
      state       <= state_nx;
      bus.RST_PER <= (state_nx != ST_COUNT);
      bus.ABORTED <= abort;
      if (start_ok) begin
        win_len_q    <= bus.WIN_LEN;
        num_win_q    <= bus.NUM_WIN;
        bus.CLK_CTRL <= bus.DLY_SEL;
        bus.TOT_ERR  <= '0;
        bus.WIN_DONE <= '0;
      end
      if (capture) begin
        bus.RESULT       <= win_err;
        bus.TOT_ERR      <= sat_add(bus.TOT_ERR, win_sum, LIM40);
        bus.WIN_DONE     <= bus.WIN_DONE + 16'd1;
        bus.RESULT_VALID <= 1'b1;
      end
      if (abort || ack_ok) bus.RESULT_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ls_cnt_seq.sv
// Directed bench for ls_cnt_seq with a behavioural error-counter model.
module tb_ls_cnt_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  // 0: no errors, 1: error every COUNT cycle, 2: last cycle only, 3: first five
  int          comp_mode = 0;
  int          cfg_win   = 0;
  logic        force_en  = 1'b0;
  logic [31:0] force_val = '0;
  logic [31:0] cnt_model;
  int          idx;

  ls_cnt_seq_if #(.WIN_W(32)) bus ();

  ls_cnt_seq #(.CLR_CYC(2), .SETTLE_CYC(4), .WIN_W(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.RST_PER) begin
      cnt_model <= '0;
      idx       <= 0;
    end else begin
      cnt_model <= cnt_model + {31'b0, bus.COMP_OUT};
      idx       <= idx + 1;
    end
  end

  always_comb begin
    bus.ERR_CNT  = force_en ? force_val : cnt_model;
    bus.COMP_OUT = 1'b0;
    if (!bus.RST_PER) begin
      case (comp_mode)
        1:       bus.COMP_OUT = 1'b1;
        2:       bus.COMP_OUT = (idx == cfg_win - 1);
        3:       bus.COMP_OUT = (idx < 5);
        default: bus.COMP_OUT = 1'b0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic start_run(input int win, input int nwin, input logic [1:0] dly);
    cfg_win     = win;
    bus.WIN_LEN = 32'(win);
    bus.NUM_WIN = 16'(nwin);
    bus.DLY_SEL = dly;
    bus.START   = 1'b1;
    @(negedge clk);
    bus.START   = 1'b0;
  endtask

  task automatic wait_valid(output int first_low, output int n_low);
    first_low = -1;
    n_low     = 0;
    for (int k = 0; k < 5000; k++) begin
      if (bus.RESULT_VALID) break;
      if (!bus.RST_PER) begin
        if (first_low < 0) first_low = k;
        n_low++;
      end
      @(negedge clk);
    end
    chk("result_valid", bus.RESULT_VALID, 1);
  endtask

  task automatic do_ack(input int dly, output int lows);
    lows = 0;
    repeat (dly) begin
      if (!bus.RST_PER) lows++;
      @(negedge clk);
    end
    bus.RESULT_ACK = 1'b1;
    @(negedge clk);
    bus.RESULT_ACK = 1'b0;
  endtask

  task automatic wait_low();
    for (int k = 0; k < 500; k++) begin
      if (!bus.RST_PER) break;
      @(negedge clk);
    end
    chk("count_entry", bus.RST_PER, 0);
  endtask

  initial begin
    int fl, nl, lows;
    rst            = 1'b1;
    bus.START      = 1'b0;
    bus.STOP       = 1'b0;
    bus.WIN_LEN    = '0;
    bus.NUM_WIN    = '0;
    bus.DLY_SEL    = '0;
    bus.RESULT_ACK = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_rst_per",  bus.RST_PER, 1);
    chk("rst_clk_ctrl", bus.CLK_CTRL, 0);
    chk("rst_result",   bus.RESULT, 0);
    chk("rst_valid",    bus.RESULT_VALID, 0);
    chk("rst_tot",      bus.TOT_ERR, 0);
    chk("rst_win_done", bus.WIN_DONE, 0);
    chk("rst_busy",     bus.BUSY, 0);
    chk("rst_aborted",  bus.ABORTED, 0);
    rst = 1'b0;
    @(negedge clk);

    // Error-free single window
    comp_mode = 0;
    start_run(100, 1, 2'd0);
    chk("t1_busy", bus.BUSY, 1);
    wait_valid(fl, nl);
    chk("t1_first_low", 64'(fl), 6);
    chk("t1_low_cycles", 64'(nl), 100);
    chk("t1_result", bus.RESULT, 0);
    do_ack(0, lows);
    chk("t1_busy_after", bus.BUSY, 0);
    chk("t1_win_done", bus.WIN_DONE, 1);
    chk("t1_valid_after", bus.RESULT_VALID, 0);

    // Exact count: every cycle, then final cycle only
    comp_mode = 1;
    start_run(10, 1, 2'd0);
    wait_valid(fl, nl);
    chk("t2_low_cycles", 64'(nl), 10);
    chk("t2_result_all", bus.RESULT, 10);
    chk("t2_tot_all", bus.TOT_ERR, 10);
    do_ack(0, lows);
    comp_mode = 2;
    start_run(10, 1, 2'd0);
    wait_valid(fl, nl);
    chk("t2_result_last", bus.RESULT, 1);
    chk("t2_tot_last", bus.TOT_ERR, 1);
    do_ack(0, lows);

    // Three windows, delayed ack, CLK_CTRL held across a DLY_SEL change
    comp_mode = 3;
    start_run(20, 3, 2'd2);
    bus.DLY_SEL = 2'd1;
    for (int w = 0; w < 3; w++) begin
      wait_valid(fl, nl);
      chk("t3_result", bus.RESULT, 5);
      chk("t3_clk_ctrl", bus.CLK_CTRL, 2);
      do_ack(7, lows);
      chk("t3_count_in_hold", 64'(lows), 0);
    end
    chk("t3_tot", bus.TOT_ERR, 15);
    chk("t3_win_done", bus.WIN_DONE, 3);
    chk("t3_busy", bus.BUSY, 0);

    // Saturation of RESULT and TOT_ERR, with WIN_LEN=0 one-cycle windows
    comp_mode = 1;
    force_en  = 1'b1;
    force_val = 32'hFFFF_FFFF;
    start_run(0, 257, 2'd0);
    for (int w = 1; w <= 257; w++) begin
      wait_valid(fl, nl);
      if (w == 1) begin
        chk("t4_result_sat", bus.RESULT, 64'hFFFF_FFFF);
        chk("t4_len0_cycles", 64'(nl), 1);
      end
      if (w == 256) chk("t4_tot_256", bus.TOT_ERR, 64'hFF_FFFF_FF00);
      if (w == 257) begin
        chk("t4_tot_sat", bus.TOT_ERR, 64'hFF_FFFF_FFFF);
        chk("t4_win_done", bus.WIN_DONE, 16'h0101);
      end
      do_ack(0, lows);
    end
    chk("t4_busy", bus.BUSY, 0);
    force_en = 1'b0;

    // STOP on the last COUNT cycle discards the capture
    comp_mode = 1;
    start_run(10, 1, 2'd0);
    wait_low();
    repeat (9) @(negedge clk);
    chk("t5_last_count", bus.RST_PER, 0);
    bus.STOP = 1'b1;
    @(negedge clk);
    bus.STOP = 1'b0;
    chk("t5_valid", bus.RESULT_VALID, 0);
    chk("t5_aborted", bus.ABORTED, 1);
    chk("t5_rst_per", bus.RST_PER, 1);
    chk("t5_busy", bus.BUSY, 0);
    @(negedge clk);
    chk("t5_aborted_pulse", bus.ABORTED, 0);

    // START with STOP in IDLE is ignored
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    chk("t6_busy", bus.BUSY, 0);
    chk("t6_aborted", bus.ABORTED, 0);
    repeat (3) @(negedge clk);
    chk("t6_rst_per", bus.RST_PER, 1);

    // Reset mid-COUNT
    comp_mode = 1;
    start_run(50, 1, 2'd3);
    wait_low();
    repeat (5) @(negedge clk);
    chk("t7_clk_ctrl_run", bus.CLK_CTRL, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_per",  bus.RST_PER, 1);
    chk("t7_clk_ctrl", bus.CLK_CTRL, 0);
    chk("t7_result",   bus.RESULT, 0);
    chk("t7_valid",    bus.RESULT_VALID, 0);
    chk("t7_tot",      bus.TOT_ERR, 0);
    chk("t7_win_done", bus.WIN_DONE, 0);
    chk("t7_busy",     bus.BUSY, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ls_cnt_seq.md
Name: ls_cnt_seq

Overview:
- Measurement-window sequencer for the latch/shift error counter (ERR_CNT / comp_out datapath).
- Drives the counter's RST_PER and CLK_CTRL to run one or more fixed-length compare windows.
- Captures an exact per-window error count and a running total, and hands each result to the host-side logic over a valid/ack handshake.
- Sits between the host command registers and the counter instance.

Parameters:
- CLR_CYC, 2, cycles RST_PER is held high in CLEAR (min 1).
- SETTLE_CYC, 4, cycles RST_PER stays high after CLEAR so the CREST sample pipeline refills after a CLK_CTRL change (min 1).
- WIN_W, 32, width of WIN_LEN and the window down-counter.

Ports:
- CLK  in  1  system clock; sole clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a run when IDLE.
- STOP  in  1  one-cycle pulse; aborts the run from any state.
- WIN_LEN  in  WIN_W  compare cycles per window; latched at START.
- NUM_WIN  in  16  windows per run; 0 = continuous until STOP; latched at START.
- DLY_SEL  in  2  value driven on CLK_CTRL for the run; latched at START.
- ERR_CNT  in  32  counter value from the error counter.
- COMP_OUT  in  1  per-cycle mismatch bit from the error counter.
- RST_PER  out  1  counter reset; registered.
- CLK_CTRL  out  2  sample-delay select to the counter; registered.
- RESULT  out  32  errors in the last completed window.
- RESULT_VALID  out  1  RESULT holds a window not yet acknowledged.
- RESULT_ACK  in  1  consumer accepts RESULT.
- TOT_ERR  out  40  saturating sum of RESULT over the run.
- WIN_DONE  out  16  windows completed in the run.
- BUSY  out  1  state != IDLE.
- ABORTED  out  1  one-cycle pulse when STOP ends a run.

Behaviour:
- Reset values: RST_PER=1, CLK_CTRL=0, RESULT=0, RESULT_VALID=0, TOT_ERR=0, WIN_DONE=0, BUSY=0, ABORTED=0; state IDLE.
- FSM states: IDLE, CLEAR, SETTLE, COUNT, HOLD.
- IDLE: RST_PER=1. On START, and only when STOP=0:
  - latch config;
  - CLK_CTRL<=DLY_SEL;
  - clear TOT_ERR and WIN_DONE;
  - go to CLEAR.
- START while BUSY is ignored.
- CLEAR: CLR_CYC cycles, then SETTLE.
- SETTLE: SETTLE_CYC cycles, then COUNT.
- COUNT: exactly max(WIN_LEN,1) cycles, with RST_PER=0 in every one of them. WIN_LEN=0 is treated as 1.
- RST_PER register next value = (next_state != COUNT). RST_PER is never combinational.
- Capture at the clock edge ending the last COUNT cycle:
  - RESULT <= sat32(ERR_CNT + COMP_OUT), i.e. ERR_CNT plus the final cycle's mismatch not yet visible in ERR_CNT; 0xFFFFFFFF + 1 stays 0xFFFFFFFF;
  - TOT_ERR <= sat40(TOT_ERR + that value);
  - WIN_DONE += 1;
  - RESULT_VALID <= 1;
  - go to HOLD.
- HOLD: RST_PER=1; waits for RESULT_ACK.
  - On ACK: RESULT_VALID <= 0.
  - If NUM_WIN != 0 and WIN_DONE == NUM_WIN, go to IDLE. RESULT/TOT_ERR/WIN_DONE hold their values until the next START.
  - Otherwise go to CLEAR for the next window. CLK_CTRL is unchanged.
- RESULT_ACK while RESULT_VALID=0 is ignored.
- Window period = CLR_CYC + SETTLE_CYC + WIN_LEN + 1 + ack wait.
- WIN_DONE wraps at 16 bits only in continuous mode.
- STOP in any non-IDLE state, highest priority (over START, ACK, capture in the same cycle):
  - go to IDLE; RST_PER=1;
  - RESULT_VALID <= 0; the partial window is discarded, including a capture that would occur in that same cycle;
  - ABORTED pulses 1 cycle.
- STOP in IDLE does nothing.
- RST mid-run: immediate return to reset values, regardless of state.

Decomposition:
- Shared package ls_pkg:
  - state encoding typedef (IDLE..HOLD);
  - CNT_W=32 and TOT_W=40;
  - sat_add helper function.
- One natural sub-module: ls_cyc_timer, a loadable down-counter with a zero flag. It is reused for the CLEAR, SETTLE and COUNT durations.
- The FSM and capture logic stay in ls_cnt_seq.

Test Plan:
- Error-free run: WIN_LEN=100, NUM_WIN=1, COMP_OUT=0.
  - RST_PER low for exactly 100 cycles, starting CLR_CYC+SETTLE_CYC=6 cycles after START.
  - RESULT=0, RESULT_VALID=1; after ACK: BUSY=0, WIN_DONE=1.
- Exact count with a real counter model: WIN_LEN=10, COMP_OUT=1 on all 10 COUNT cycles (including the last) -> RESULT=10 and TOT_ERR=10. Then COMP_OUT=1 only on the final cycle -> RESULT=1.
- Multi-window totals: NUM_WIN=3, 5 errors per window, ACK delayed 7 cycles each time.
  - Three RESULT_VALID assertions, each RESULT=5.
  - TOT_ERR=15, WIN_DONE=3.
  - No COUNT cycle occurs while RESULT_VALID=1.
- Saturation: ERR_CNT forced to 0xFFFFFFFF with COMP_OUT=1 at capture -> RESULT=0xFFFFFFFF. Preloaded TOT_ERR near 2^40-1 clamps to 2^40-1.
- Abort and priority:
  - STOP on the last COUNT cycle -> RESULT_VALID stays 0, ABORTED=1 for 1 cycle, RST_PER=1.
  - START and STOP in the same cycle in IDLE -> stays IDLE.
- Config and reset:
  - DLY_SEL=2 at START, changed to 1 mid-run -> CLK_CTRL stays 2.
  - WIN_LEN=0 -> 1-cycle window.
  - RST asserted in COUNT -> next cycle all outputs at reset values, RST_PER=1.
